// File: rtl/display_gamma_lut_loader.sv
// Streams one full gamma table (2**bitwidth entries) from the host into one encoder LUT and holds off the pixel path while writing.
// Optional build macro DISPLAY_LUT_CHECKSUM_EN adds lut_checksum, the 16-bit running sum of the accepted entries.
module display_gamma_lut_loader #(
   parameter int bitwidth     = 8,
   parameter int cyclewidth   = 8,
   parameter int channels     = 3,
   parameter int drain_cycles = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [3:0]            load_channel,
   input  logic                  load_valid,
   input  logic [cyclewidth-1:0] load_data,
   output logic                  load_ready,
   output logic                  load_done,
   output logic                  load_error,
   output logic                  busy,
   output logic                  pix_ready,
   output logic [channels-1:0]   lut_we,
   output logic [bitwidth-1:0]   lut_addr,
   output logic [cyclewidth-1:0] lut_wdata,
`ifdef DISPLAY_LUT_CHECKSUM_EN
   output logic [15:0]           lut_checksum,
`endif
   output logic [1:0]            dbg_state
);

   // Handshake: an entry is accepted on a rising edge where load_valid && load_ready are both high;
   // load_ready depends only on state, and load_data must be stable while load_valid is high.

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LOAD, S_DONE} state_t;

   localparam int DCW = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(drain_cycles - 1);
   localparam logic [4:0] NUM_CH = 5'(channels);

   state_t                state, next_state;
   logic [DCW-1:0]        drain_cnt;
   logic [bitwidth-1:0]   addr;
   logic [3:0]            ch_q;
   logic [channels-1:0]   we_onehot;
   logic                  chan_ok;
   logic                  start_ok;
   logic                  accept;

   assign chan_ok  = ({1'b0, load_channel} < NUM_CH);
   assign start_ok = (state == S_IDLE) && load_start && chan_ok;
   assign accept   = load_valid && load_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      load_ready = 1'b0;
      load_done  = 1'b0;
      busy       = 1'b1;
      pix_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            busy      = 1'b0;
            pix_ready = 1'b1;
            if (start_ok) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) next_state = S_LOAD;
         end
         S_LOAD: begin
            load_ready = 1'b1;
            if (load_valid && (addr == '1)) next_state = S_DONE;
         end
         S_DONE: begin
            load_done  = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      we_onehot = '0;
      for (int i = 0; i < channels; i++) begin
         if (ch_q == 4'(i)) we_onehot[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt  <= '0;
         addr       <= '0;
         ch_q       <= '0;
         load_error <= 1'b0;
         lut_we     <= '0;
         lut_addr   <= '0;
         lut_wdata  <= '0;
      end else begin
         load_error <= (state == S_IDLE) && load_start && !chan_ok;
         if (start_ok) ch_q <= load_channel;
         if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else                  drain_cnt <= '0;
         // Write port is registered: the accepted entry lands one cycle after the handshake.
         if (accept) begin
            lut_we    <= we_onehot;
            lut_addr  <= addr;
            lut_wdata <= load_data;
            addr      <= addr + 1'b1;
         end else begin
            lut_we    <= '0;
         end
      end
   end

`ifdef DISPLAY_LUT_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         lut_checksum <= '0;
      else if (start_ok) lut_checksum <= '0;
      else if (accept) lut_checksum <= lut_checksum + 16'(load_data);
   end
`endif

   assign dbg_state = state;

endmodule
